// File: rtl/fetch_bus.sv
// rtl/fetch_bus.sv - single-entry instruction fetch holding register with one-outstanding bus master
// Optional misaligned-PC trap is enabled by defining CYBERRIO_FETCH_MISALIGN_TRAP_EN.
module fetch_bus (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] fetch_address,
    output logic [31:0] fetch_data,
    output logic        fetch_ready,
    output logic        fetch_error,
    input  logic        flush,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    input  logic        mem_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] data_q, data_d;
    logic [29:0] addr_q, addr_d;
    logic        err_q, err_d;
    logic        valid_q, valid_d;
    logic [29:0] req_addr_q, req_addr_d;
    logic        abort_q, abort_d;

    logic hit;
    logic misalign;

    assign hit = valid_q && (addr_q == fetch_address[31:2]);

`ifdef CYBERRIO_FETCH_MISALIGN_TRAP_EN
    assign misalign = (fetch_address[1:0] != 2'b00);
`else
    logic unused_addr_bits;
    assign misalign         = 1'b0;
    assign unused_addr_bits = ^fetch_address[1:0];
`endif

    // A misaligned PC answers immediately with an error and never touches the bus.
    always_comb begin
        fetch_ready = hit || misalign;
        fetch_error = misalign || err_q;
        fetch_data  = misalign ? 32'h0 : data_q;
    end

    assign mem_req  = (state_q == REQ);
    assign mem_addr = {req_addr_q, 2'b00};

    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        addr_d     = addr_q;
        err_d      = err_q;
        valid_d    = valid_q;
        req_addr_d = req_addr_q;
        abort_d    = abort_q;

        case (state_q)
            IDLE: begin
                if (!hit && !flush && !misalign) begin
                    req_addr_d = fetch_address[31:2];
                    abort_d    = 1'b0;
                    state_d    = REQ;
                end
            end
            REQ: begin
                if (mem_gnt) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (mem_rvalid) begin
                    state_d = IDLE;
                    // The fill lands even if the PC moved on; only flush discards it.
                    if (!abort_q && !flush) begin
                        data_d  = mem_rdata;
                        addr_d  = req_addr_q;
                        err_d   = mem_err;
                        valid_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (flush) begin
            valid_d = 1'b0;
            if (state_q != IDLE) begin
                abort_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            data_q     <= 32'h0;
            addr_q     <= 30'h0;
            err_q      <= 1'b0;
            valid_q    <= 1'b0;
            req_addr_q <= 30'h0;
            abort_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            addr_q     <= addr_d;
            err_q      <= err_d;
            valid_q    <= valid_d;
            req_addr_q <= req_addr_d;
            abort_q    <= abort_d;
        end
    end

endmodule

// File: tb/tb_fetch_bus.sv
// tb/tb_fetch_bus.sv - table-driven scoreboard bench for fetch_bus
module tb_fetch_bus;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] fetch_address;
    logic [31:0] fetch_data;
    logic        fetch_ready;
    logic        fetch_error;
    logic        flush;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        mem_err;

    fetch_bus dut (
        .clk           (clk),
        .reset         (reset),
        .fetch_address (fetch_address),
        .fetch_data    (fetch_data),
        .fetch_ready   (fetch_ready),
        .fetch_error   (fetch_error),
        .flush         (flush),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_gnt       (mem_gnt),
        .mem_rvalid    (mem_rvalid),
        .mem_rdata     (mem_rdata),
        .mem_err       (mem_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int req_cycles = 0;

    always @(posedge clk) begin
        if (mem_req === 1'b1) req_cycles <= req_cycles + 1;
    end

    typedef struct {
        logic [31:0] data;
        logic        err;
    } resp_t;
    resp_t sb_q[$];

    typedef struct {
        logic [31:0] addr;
        logic [31:0] rdata;
        logic        err;
        int          gdly;
        logic [31:0] exp_data;
        logic        exp_err;
        string       name;
    } vec_t;
    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Miss from IDLE, grant after gdly stall cycles, response the cycle after grant.
    task automatic fetch_txn(input logic [31:0] addr, input logic [31:0] rdata, input logic err,
                             input int gdly, input string tag);
        int    base;
        resp_t r;
        fetch_address = addr;
        mem_gnt       = 1'b0;
        base          = req_cycles;
        #1;
        check($sformatf("%s miss", tag), 32'(fetch_ready), 32'd0);
        step();
        check($sformatf("%s req", tag), 32'(mem_req), 32'd1);
        check($sformatf("%s addr", tag), mem_addr, {addr[31:2], 2'b00});
        if (mem_req !== 1'b1) return;
        for (int i = 0; i < gdly; i++) begin
            step();
            check($sformatf("%s stall req", tag), 32'(mem_req), 32'd1);
            check($sformatf("%s stall addr", tag), mem_addr, {addr[31:2], 2'b00});
        end
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        check($sformatf("%s req drop", tag), 32'(mem_req), 32'd0);
        mem_rvalid = 1'b1;
        mem_rdata  = rdata;
        mem_err    = err;
        sb_q.push_back('{data: rdata, err: err});
        check($sformatf("%s not ready yet", tag), 32'(fetch_ready), 32'd0);
        step();
        mem_rvalid = 1'b0;
        mem_err    = 1'b0;
        mem_rdata  = $urandom;
        check($sformatf("%s ready", tag), 32'(fetch_ready), 32'd1);
        if (sb_q.size() > 0) begin
            r = sb_q.pop_front();
            check($sformatf("%s data", tag), fetch_data, r.data);
            check($sformatf("%s err", tag), 32'(fetch_error), 32'(r.err));
        end else begin
            check($sformatf("%s scoreboard", tag), 32'(sb_q.size()), 32'd1);
        end
        check($sformatf("%s req cycles", tag), 32'(req_cycles - base), 32'(gdly + 1));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int    base;
        resp_t r;

        vecs[0] = '{32'h8000_0000, 32'h0000_0013, 1'b0, 0, 32'h0000_0013, 1'b0, "cold"};
        vecs[1] = '{32'h8000_0004, 32'h00A0_0093, 1'b0, 4, 32'h00A0_0093, 1'b0, "gnt_stall"};
        vecs[2] = '{32'h8000_0010, 32'hBAD0_0000, 1'b1, 0, 32'hBAD0_0000, 1'b1, "bus_err"};
        vecs[3] = '{32'h8000_0020, 32'hCAFE_F00D, 1'b0, 2, 32'hCAFE_F00D, 1'b0, "stall2"};
        vecs[4] = '{32'h0000_0FFC, 32'hFFFF_FFFF, 1'b0, 1, 32'hFFFF_FFFF, 1'b0, "low_addr"};

        reset         = 1'b1;
        flush         = 1'b0;
        mem_gnt       = 1'b0;
        mem_rvalid    = 1'b0;
        mem_rdata     = 32'h0;
        mem_err       = 1'b0;
        fetch_address = 32'h8000_0000;
        step();
        step();
        check("reset mem_req", 32'(mem_req), 32'd0);
        check("reset ready", 32'(fetch_ready), 32'd0);
        check("reset data", fetch_data, 32'd0);
        check("reset error", 32'(fetch_error), 32'd0);
        reset = 1'b0;

        for (int v = 0; v < 5; v++) begin
            fetch_txn(vecs[v].addr, vecs[v].rdata, vecs[v].err, vecs[v].gdly, vecs[v].name);
            base = req_cycles;
            step();
            step();
            check($sformatf("%s hold ready", vecs[v].name), 32'(fetch_ready), 32'd1);
            check($sformatf("%s hold data", vecs[v].name), fetch_data, vecs[v].exp_data);
            check($sformatf("%s hold err", vecs[v].name), 32'(fetch_error), 32'(vecs[v].exp_err));
            check($sformatf("%s hold no req", vecs[v].name), 32'(req_cycles - base), 32'd0);
        end

        // Redirect while WAIT: old fill stored, then new request for the new PC.
        fetch_address = 32'h8000_0008;
        step();
        check("redir req addr", mem_addr, 32'h8000_0008);
        mem_gnt = 1'b1;
        step();
        mem_gnt       = 1'b0;
        fetch_address = 32'h8000_0100;
        mem_rvalid    = 1'b1;
        mem_rdata     = 32'h1111_1111;
        step();
        mem_rvalid = 1'b0;
        check("redir ready", 32'(fetch_ready), 32'd0);
        check("redir stored", fetch_data, 32'h1111_1111);
        fetch_txn(32'h8000_0100, 32'h2222_2222, 1'b0, 0, "redir new");

        // Flush while WAIT: response discarded, refetch of the current PC.
        fetch_address = 32'h8000_0040;
        step();
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        flush   = 1'b1;
        step();
        flush      = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hDEAD_BEEF;
        step();
        mem_rvalid = 1'b0;
        check("flush ready", 32'(fetch_ready), 32'd0);
        check("flush data kept", fetch_data, 32'h2222_2222);
        check("flush sb empty", 32'(sb_q.size()), 32'd0);
        fetch_txn(32'h8000_0040, 32'h3333_3333, 1'b0, 0, "refetch");

        // Flush while holding a hit invalidates the word.
        flush = 1'b1;
        #1;
        check("idle flush before", 32'(fetch_ready), 32'd1);
        step();
        flush = 1'b0;
        check("idle flush after", 32'(fetch_ready), 32'd0);
        fetch_txn(32'h8000_0040, 32'h4444_4444, 1'b0, 0, "post flush");

        // Reset mid-transaction, late response ignored, request reissued next cycle.
        fetch_address = 32'h8000_0200;
        step();
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        reset   = 1'b1;
        step();
        reset      = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h5555_5555;
        step();
        mem_rvalid = 1'b0;
        check("rst late ready", 32'(fetch_ready), 32'd0);
        check("rst late data", fetch_data, 32'd0);
        check("rst reissue req", 32'(mem_req), 32'd1);
        check("rst reissue addr", mem_addr, 32'h8000_0200);
        mem_gnt = 1'b1;
        step();
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h6666_6666;
        sb_q.push_back('{data: 32'h6666_6666, err: 1'b0});
        step();
        mem_rvalid = 1'b0;
        check("rst fill ready", 32'(fetch_ready), 32'd1);
        if (sb_q.size() > 0) begin
            r = sb_q.pop_front();
            check("rst fill data", fetch_data, r.data);
        end else begin
            check("rst fill scoreboard", 32'(sb_q.size()), 32'd1);
        end

`ifdef CYBERRIO_FETCH_MISALIGN_TRAP_EN
        fetch_address = 32'h8000_0002;
        base          = req_cycles;
        #1;
        check("misalign ready", 32'(fetch_ready), 32'd1);
        check("misalign error", 32'(fetch_error), 32'd1);
        check("misalign data", fetch_data, 32'd0);
        step();
        step();
        step();
        check("misalign no req", 32'(req_cycles - base), 32'd0);
        check("misalign mem_req", 32'(mem_req), 32'd0);
`else
        fetch_txn(32'h8000_0002, 32'h7777_7777, 1'b0, 0, "misalign");
        check("misalign word addr", mem_addr, 32'h8000_0000);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
